// File: rtl/param_shift_reg_if.sv
// Bus bundle for param_shift_reg: operation controls, burst request and
// register/serial/status outputs. slave = register side, master = driver.
interface param_shift_reg_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
);
  logic               en;
  logic [2:0]         mode;
  logic [WIDTH-1:0]   load_val;
  logic               ser_in_l;
  logic               ser_in_r;
  logic               start;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   Q;
  logic               ser_out_l;
  logic               ser_out_r;
  logic               busy;
  logic               done;

  modport slave (
    input  en, mode, load_val,
    input  ser_in_l, ser_in_r,
    input  start, shamt,
    output Q, ser_out_l, ser_out_r,
    output busy, done
  );

  modport master (
    output en, mode, load_val,
    output ser_in_l, ser_in_r,
    output start, shamt,
    input  Q, ser_out_l, ser_out_r,
    input  busy, done
  );
endinterface

// File: rtl/param_shift_reg.sv
// WIDTH-bit universal register (hold/load/clear/shift/rotate) with a
// counted burst mode. Ports: Clk, rst (sync, active-high), bus (slave).
module param_shift_reg #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic Clk,
  input logic rst,
  param_shift_reg_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [WIDTH-1:0]   q_r, q_nx;
  logic [0:0]         state_r, state_nx;
  logic [SHAMT_W-1:0] cnt_r, cnt_nx;
  logic [2:0]         mode_r, mode_nx;
  logic               done_r, done_nx;

  function automatic logic is_shift(
    input logic [2:0] m
  );
    return m inside {3'b001, 3'b010, 3'b011,
                     3'b100, 3'b110};
  endfunction

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] lv,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] r;
    r = q;
    case (m)
      3'b000: r = q;
      3'b001: r = {q[WIDTH-2:0], sr};
      3'b010: r = {sl, q[WIDTH-1:1]};
      3'b011: r = {q[WIDTH-2:0], q[WIDTH-1]};
      3'b100: r = {q[0], q[WIDTH-1:1]};
      3'b101: r = lv;
      3'b110: r = {q[WIDTH-1], q[WIDTH-1:1]};
      3'b111: r = '0;
      default: r = q;
    endcase
    return r;
  endfunction

  always_comb begin
    q_nx     = q_r;
    state_nx = state_r;
    cnt_nx   = cnt_r;
    mode_nx  = mode_r;
    done_nx  = 1'b0;
    unique case (state_r)
      IDLE: begin
        if (bus.start && is_shift(bus.mode)) begin
          if (bus.shamt == '0) begin
            done_nx = 1'b1;
          end else begin
            q_nx    = apply_op(bus.mode, q_r,
                               bus.load_val,
                               bus.ser_in_l,
                               bus.ser_in_r);
            mode_nx = bus.mode;
            if (bus.shamt == SHAMT_W'(1)) begin
              done_nx = 1'b1;
            end else begin
              cnt_nx   = bus.shamt - 1'b1;
              state_nx = RUN;
            end
          end
        end else if (bus.en) begin
          q_nx = apply_op(bus.mode, q_r,
                          bus.load_val,
                          bus.ser_in_l,
                          bus.ser_in_r);
        end
      end
      RUN: begin
        // Serial inputs stay live; everything else is locked out.
        q_nx   = apply_op(mode_r, q_r,
                          bus.load_val,
                          bus.ser_in_l,
                          bus.ser_in_r);
        cnt_nx = cnt_r - 1'b1;
        if (cnt_r == SHAMT_W'(1)) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      q_r     <= RESET_VAL;
      state_r <= IDLE;
      cnt_r   <= '0;
      mode_r  <= 3'b000;
      done_r  <= 1'b0;
    end else begin
      q_r     <= q_nx;
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      mode_r  <= mode_nx;
      done_r  <= done_nx;
    end
  end

  assign bus.Q         = q_r;
  assign bus.ser_out_l = q_r[WIDTH-1];
  assign bus.ser_out_r = q_r[0];
  assign bus.busy      = (state_r == RUN);
  assign bus.done      = done_r;

endmodule

// File: tb/tb_param_shift_reg.sv
// Self-checking bench for param_shift_reg (WIDTH=8, RESET_VAL=3C):
// directed steps from the test plan, then random traffic vs a model.
module tb_param_shift_reg;

  logic Clk = 1'b0;
  logic rst;

  param_shift_reg_if #(.WIDTH(8), .SHAMT_W(4)) bus ();

  param_shift_reg #(
    .WIDTH(8),
    .SHAMT_W(4),
    .RESET_VAL(8'h3C)
  ) dut (
    .Clk(Clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: register value, remaining burst shifts,
  // latched burst mode and the done flag.
  int mq;
  int mrem;
  int mmode;
  int mdone;

  function automatic int ref_op(
    input int m, input int v, input int lv,
    input int sl, input int sr
  );
    case (m)
      1: return (v * 2 + sr) % 256;
      2: return v / 2 + sl * 128;
      3: return (v * 2) % 256 + v / 128;
      4: return v / 2 + (v % 2) * 128;
      5: return lv;
      6: return v / 2 + (v / 128) * 128;
      7: return 0;
      default: return v;
    endcase
  endfunction

  function automatic bit shift_class(input int m);
    return m == 1 || m == 2 || m == 3 ||
           m == 4 || m == 6;
  endfunction

  task automatic model_edge();
    int m, lv, sl, sr, sh;
    m  = int'(bus.mode);
    lv = int'(bus.load_val);
    sl = int'(bus.ser_in_l);
    sr = int'(bus.ser_in_r);
    sh = int'(bus.shamt);
    if (rst) begin
      mq = 8'h3C; mrem = 0; mdone = 0;
    end else if (mrem > 0) begin
      mq    = ref_op(mmode, mq, lv, sl, sr);
      mrem  = mrem - 1;
      mdone = (mrem == 0);
    end else begin
      mdone = 0;
      if (bus.start && shift_class(m)) begin
        if (sh == 0) begin
          mdone = 1;
        end else begin
          mq    = ref_op(m, mq, lv, sl, sr);
          mmode = m;
          mrem  = sh - 1;
          mdone = (sh == 1);
        end
      end else if (bus.en) begin
        mq = ref_op(m, mq, lv, sl, sr);
      end
    end
  endtask

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    chk("q", bus.Q, mq);
    chk("busy", bus.busy, mrem > 0);
    chk("done", bus.done, mdone);
    chk("sol", bus.ser_out_l, mq / 128);
    chk("sor", bus.ser_out_r, mq % 2);
  endtask

  task automatic idle_in();
    bus.en = 0; bus.start = 0; bus.mode = 0;
    bus.shamt = 0; bus.load_val = 0;
    bus.ser_in_l = 0; bus.ser_in_r = 0;
  endtask

  task automatic load(input logic [7:0] v);
    idle_in();
    bus.en = 1; bus.mode = 3'b101;
    bus.load_val = v;
    step();
    idle_in();
  endtask

  task automatic single(
    input string tag, input logic [2:0] m,
    input logic sl, input logic sr,
    input logic [7:0] exp
  );
    load(8'hA5);
    bus.en = 1; bus.mode = m;
    bus.ser_in_l = sl; bus.ser_in_r = sr;
    step();
    chk(tag, bus.Q, exp);
    idle_in();
  endtask

  initial begin
    mq = 0; mrem = 0; mmode = 0; mdone = 0;
    idle_in();
    rst = 1;
    step();
    step();
    chk("rst_q", bus.Q, 8'h3C);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    rst = 0;

    load(8'hA5);
    chk("load_en", bus.Q, 8'hA5);
    chk("sol_a5", bus.ser_out_l, 1'b1);
    chk("sor_a5", bus.ser_out_r, 1'b1);
    rst = 1; #3; rst = 0; #1;
    chk("rst_sync", bus.Q, 8'hA5);
    bus.mode = 3'b101; bus.load_val = 8'h00;
    step();
    chk("load_noen", bus.Q, 8'hA5);
    idle_in();

    single("shl", 3'b001, 1'b0, 1'b1, 8'h4B);
    single("shr", 3'b010, 1'b0, 1'b0, 8'h52);
    chk("sol_52", bus.ser_out_l, 1'b0);
    chk("sor_52", bus.ser_out_r, 1'b0);
    single("asr", 3'b110, 1'b0, 1'b0, 8'hD2);
    single("rol", 3'b011, 1'b0, 1'b0, 8'h4B);
    single("ror", 3'b100, 1'b0, 1'b0, 8'hD2);
    single("clr", 3'b111, 1'b0, 1'b0, 8'h00);

    load(8'h81);
    bus.mode = 3'b011; bus.start = 1;
    bus.shamt = 3;
    step();
    chk("rol_e1_q", bus.Q, 8'h03);
    chk("rol_e1_busy", bus.busy, 1'b1);
    idle_in();
    step();
    chk("rol_e2_q", bus.Q, 8'h06);
    chk("rol_e2_busy", bus.busy, 1'b1);
    step();
    chk("rol_e3_q", bus.Q, 8'h0C);
    chk("rol_e3_done", bus.done, 1'b1);
    chk("rol_e3_busy", bus.busy, 1'b0);
    step();
    chk("rol_e4_done", bus.done, 1'b0);
    chk("rol_e4_busy", bus.busy, 1'b0);

    load(8'h00);
    bus.mode = 3'b001; bus.start = 1;
    bus.shamt = 4; bus.ser_in_r = 1;
    step();
    bus.mode = 3'b101; bus.en = 1;
    bus.load_val = 8'hFF; bus.shamt = 2;
    bus.ser_in_r = 0;
    step();
    bus.mode = 3'b111; bus.ser_in_r = 1;
    step();
    bus.start = 0; bus.ser_in_r = 1;
    step();
    chk("burst_ign_q", bus.Q, 8'h0B);
    chk("burst_ign_done", bus.done, 1'b1);
    idle_in();
    step();
    chk("burst_ign_hold", bus.Q, 8'h0B);

    bus.mode = 3'b001; bus.start = 1;
    bus.shamt = 0; bus.en = 1;
    step();
    chk("sh0_q", bus.Q, 8'h0B);
    chk("sh0_done", bus.done, 1'b1);
    chk("sh0_busy", bus.busy, 1'b0);
    idle_in();
    step();
    chk("sh0_done_clr", bus.done, 1'b0);

    bus.mode = 3'b010; bus.start = 1;
    bus.shamt = 1; bus.ser_in_l = 1;
    step();
    chk("sh1_q", bus.Q, 8'h85);
    chk("sh1_done", bus.done, 1'b1);
    chk("sh1_busy", bus.busy, 1'b0);
    idle_in();
    step();

    bus.mode = 3'b101; bus.start = 1;
    bus.shamt = 3; bus.load_val = 8'h5A;
    step();
    chk("st_ld_noen", bus.Q, 8'h85);
    bus.en = 1;
    step();
    chk("st_ld_en", bus.Q, 8'h5A);
    chk("st_ld_done", bus.done, 1'b0);
    idle_in();

    bus.mode = 3'b100; bus.start = 1;
    bus.shamt = 5;
    step();
    chk("mid_e1_q", bus.Q, 8'h2D);
    idle_in();
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_q", bus.Q, 8'h3C);
    chk("mid_rst_busy", bus.busy, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mid_no_done", bus.done, 1'b0);
    end

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      bus.en = 1'($urandom);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.mode = 3'($urandom);
      bus.shamt = 4'($urandom_range(0, 6));
      bus.load_val = 8'($urandom);
      bus.ser_in_l = 1'($urandom);
      bus.ser_in_r = 1'($urandom);
      step();
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
